muovi_quadrato: RTL and testbench

MUOVI_QUADRATO -- requirements
Module: muovi_quadrato

---
 rtl/muovi_quadrato.sv | 148 ++++++++++++++
 tb/tb_muovi_quadrato.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muovi_quadrato.sv
// Moves a square's centre by a per-frame step that accelerates while a direction is held.
// X wraps around the screen width; Y is clamped so the square never leaves the screen.
module muovi_quadrato #(
    parameter int H          = 1280,
    parameter int V          = 1024,
    parameter int ALTEZZA    = 100,
    parameter int X_INIT     = 640,
    parameter int Y_INIT     = 512,
    parameter int PASSO_MIN  = 1,
    parameter int PASSO_MAX  = 8,
    parameter int ACC_FRAMES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FRAME_TICK,
    input  logic        ABILITA,
    input  logic        SU,
    input  logic        GIU,
    input  logic        SINISTRA,
    input  logic        DESTRA,
    output logic [10:0] X_POS,
    output logic [10:0] Y_POS,
    output logic        IN_MOTO,
    output logic        AGGIORNATO,
    output logic [1:0]  stato_dbg,
    output logic [3:0]  vel_dbg
);

    localparam int ACC_W = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;
    localparam int YMIN  = ALTEZZA / 2;
    localparam int YMAX  = V - 1 - ALTEZZA / 2;

    localparam logic [11:0]      H_12      = 12'(H);
    localparam logic [11:0]      YMIN_12   = 12'(YMIN);
    localparam logic [11:0]      YMAX_12   = 12'(YMAX);
    localparam logic [3:0]       P_MIN_4   = 4'(PASSO_MIN);
    localparam logic [3:0]       P_MAX_4   = 4'(PASSO_MAX);
    localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(ACC_FRAMES - 1);
    localparam logic [ACC_W-1:0] ACC_UNO   = ACC_W'(1);

    typedef enum logic [1:0] {
        FERMO = 2'd0,
        MOTO  = 2'd1,
        MAX   = 2'd2
    } stato_t;

    stato_t             stato_q, stato_d;
    logic [3:0]         vel_q, vel_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [10:0]        x_q, x_d;
    logic [10:0]        y_q, y_d;
    logic               agg_q, agg_d;

    logic               h_dir, v_dir, muove;
    logic [11:0]        x_12, y_12, vel_12;
    logic [11:0]        x_destra, x_sinistra, y_giu, y_su;
    logic [10:0]        x_mosso, y_mosso;

    // Handshake: FRAME_TICK is a single-cycle strobe; state moves only in that cycle,
    // and AGGIORNATO answers every enabled tick with a single-cycle pulse one cycle later.
    assign h_dir = SINISTRA ^ DESTRA;
    assign v_dir = SU ^ GIU;
    assign muove = ABILITA && (h_dir || v_dir);

    assign x_12   = {1'b0, x_q};
    assign y_12   = {1'b0, y_q};
    assign vel_12 = {8'd0, vel_q};

    // 12-bit sums keep every intermediate positive and free of overflow.
    assign x_destra   = x_12 + vel_12;
    assign x_sinistra = x_12 + H_12 - vel_12;
    assign y_giu      = y_12 + vel_12;
    assign y_su       = y_12 - vel_12;

    always_comb begin
        x_mosso = x_q;
        if (h_dir && DESTRA) begin
            x_mosso = (x_destra >= H_12) ? 11'(x_destra - H_12) : 11'(x_destra);
        end else if (h_dir && SINISTRA) begin
            x_mosso = (x_12 < vel_12) ? 11'(x_sinistra) : 11'(x_12 - vel_12);
        end
    end

    always_comb begin
        y_mosso = y_q;
        if (v_dir && GIU) begin
            y_mosso = (y_giu > YMAX_12) ? 11'(YMAX_12) : 11'(y_giu);
        end else if (v_dir && SU) begin
            // Compare before subtracting so a large step cannot wrap below zero.
            y_mosso = (y_12 < YMIN_12 + vel_12) ? 11'(YMIN_12) : 11'(y_su);
        end
    end

    always_comb begin
        stato_d = stato_q;
        vel_d   = vel_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        agg_d   = 1'b0;
        if (FRAME_TICK) begin
            agg_d = ABILITA;
            if (muove) begin
                x_d = x_mosso;
                y_d = y_mosso;
                if (acc_q == ACC_LAST) begin
                    acc_d = '0;
                    if (vel_q < P_MAX_4) begin
                        vel_d = vel_q + 4'd1;
                    end
                end else begin
                    acc_d = acc_q + ACC_UNO;
                end
                stato_d = (vel_d == P_MAX_4) ? MAX : MOTO;
            end else begin
                stato_d = FERMO;
                vel_d   = P_MIN_4;
                acc_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stato_q <= FERMO;
            vel_q   <= P_MIN_4;
            acc_q   <= '0;
            x_q     <= 11'(X_INIT);
            y_q     <= 11'(Y_INIT);
            agg_q   <= 1'b0;
        end else begin
            stato_q <= stato_d;
            vel_q   <= vel_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            agg_q   <= agg_d;
        end
    end

    assign X_POS      = x_q;
    assign Y_POS      = y_q;
    assign IN_MOTO    = (stato_q != FERMO);
    assign AGGIORNATO = agg_q;
    assign stato_dbg  = stato_q;
    assign vel_dbg    = vel_q;

endmodule

// File: tb/tb_muovi_quadrato.sv
// Bench for muovi_quadrato: three instances with different start points share one stimulus
// stream; an arithmetic model predicts every AGGIORNATO response.
module tb_muovi_quadrato;

    localparam int H    = 1280;
    localparam int YMIN = 50;
    localparam int YMAX = 973;
    localparam int PMIN = 1;
    localparam int PMAX = 8;
    localparam int ACCF = 4;
    localparam int N    = 3;

    logic clk = 1'b0;
    logic rst, frame_tick, abilita, su, giu, sinistra, destra;
    logic [10:0] x_pos [N];
    logic [10:0] y_pos [N];
    logic        in_moto [N];
    logic        aggiornato [N];
    logic [1:0]  stato [N];
    logic [3:0]  vel [N];

    int n_tests = 0;
    int n_fail  = 0;

    // Expected response: {in_moto, vel, x, y}
    logic [26:0] exp_q0[$];
    logic [26:0] exp_q1[$];
    logic [26:0] exp_q2[$];

    int x_init [N] = '{640, 1278, 0};
    int y_init [N] = '{512, 52, 972};
    int mx [N];
    int my [N];
    int run_len [N];

    always #5 clk = ~clk;

    muovi_quadrato u_def (
        .CLK(clk), .RESET(rst), .FRAME_TICK(frame_tick), .ABILITA(abilita),
        .SU(su), .GIU(giu), .SINISTRA(sinistra), .DESTRA(destra),
        .X_POS(x_pos[0]), .Y_POS(y_pos[0]), .IN_MOTO(in_moto[0]), .AGGIORNATO(aggiornato[0]),
        .stato_dbg(stato[0]), .vel_dbg(vel[0])
    );

    muovi_quadrato #(.X_INIT(1278), .Y_INIT(52)) u_a (
        .CLK(clk), .RESET(rst), .FRAME_TICK(frame_tick), .ABILITA(abilita),
        .SU(su), .GIU(giu), .SINISTRA(sinistra), .DESTRA(destra),
        .X_POS(x_pos[1]), .Y_POS(y_pos[1]), .IN_MOTO(in_moto[1]), .AGGIORNATO(aggiornato[1]),
        .stato_dbg(stato[1]), .vel_dbg(vel[1])
    );

    muovi_quadrato #(.X_INIT(0), .Y_INIT(972)) u_b (
        .CLK(clk), .RESET(rst), .FRAME_TICK(frame_tick), .ABILITA(abilita),
        .SU(su), .GIU(giu), .SINISTRA(sinistra), .DESTRA(destra),
        .X_POS(x_pos[2]), .Y_POS(y_pos[2]), .IN_MOTO(in_moto[2]), .AGGIORNATO(aggiornato[2]),
        .stato_dbg(stato[2]), .vel_dbg(vel[2])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Step grows by one every ACCF moving frames, capped at PMAX.
    function automatic int step_of(input int r);
        int v;
        v = PMIN + r / ACCF;
        return (v > PMAX) ? PMAX : v;
    endfunction

    task automatic push_exp(input int k, input logic [26:0] e);
        case (k)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic model_tick(input int k, input bit ab, input bit s_u, input bit g_i,
                              input bit s_n, input bit d_e);
        int dx, dy, v;
        dx = (d_e && !s_n) ? 1 : ((s_n && !d_e) ? -1 : 0);
        dy = (g_i && !s_u) ? 1 : ((s_u && !g_i) ? -1 : 0);
        if (!ab) begin
            run_len[k] = 0;
        end else if (dx == 0 && dy == 0) begin
            run_len[k] = 0;
            push_exp(k, {1'b0, 4'(PMIN), 11'(mx[k]), 11'(my[k])});
        end else begin
            v = step_of(run_len[k]);
            mx[k] = (mx[k] + dx * v + H) % H;
            my[k] = my[k] + dy * v;
            if (my[k] < YMIN) my[k] = YMIN;
            if (my[k] > YMAX) my[k] = YMAX;
            run_len[k]++;
            push_exp(k, {1'b1, 4'(step_of(run_len[k])), 11'(mx[k]), 11'(my[k])});
        end
    endtask

    task automatic mon(input int k);
        logic [26:0] e;
        int sz;
        case (k)
            0: sz = exp_q0.size();
            1: sz = exp_q1.size();
            default: sz = exp_q2.size();
        endcase
        n_tests++;
        if (sz == 0) begin
            n_fail++;
            $display("FAIL agg_spurious[%0d]: AGGIORNATO high, expected queue size 0", k);
            return;
        end
        case (k)
            0: e = exp_q0.pop_front();
            1: e = exp_q1.pop_front();
            default: e = exp_q2.pop_front();
        endcase
        check($sformatf("mon_x[%0d]", k), 32'(x_pos[k]), 32'(e[21:11]));
        check($sformatf("mon_y[%0d]", k), 32'(y_pos[k]), 32'(e[10:0]));
        check($sformatf("mon_vel[%0d]", k), 32'(vel[k]), 32'(e[25:22]));
        check($sformatf("mon_in_moto[%0d]", k), 32'(in_moto[k]), 32'(e[26]));
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (aggiornato[k] === 1'b1) mon(k);
        end
    end

    task automatic do_tick(input bit ab, input bit s_u, input bit g_i, input bit s_n, input bit d_e);
        @(negedge clk);
        abilita = ab; su = s_u; giu = g_i; sinistra = s_n; destra = d_e;
        frame_tick = 1'b1;
        for (int k = 0; k < N; k++) model_tick(k, ab, s_u, g_i, s_n, d_e);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Reset lands away from any clock edge, so the checks see the asynchronous path.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_x[%0d]", k), 32'(x_pos[k]), 32'(x_init[k]));
            check($sformatf("rst_y[%0d]", k), 32'(y_pos[k]), 32'(y_init[k]));
            check($sformatf("rst_in_moto[%0d]", k), 32'(in_moto[k]), 32'd0);
            check($sformatf("rst_agg[%0d]", k), 32'(aggiornato[k]), 32'd0);
            check($sformatf("rst_vel[%0d]", k), 32'(vel[k]), 32'(PMIN));
            mx[k] = x_init[k];
            my[k] = y_init[k];
            run_len[k] = 0;
        end
        check("q_left0", 32'(exp_q0.size()), 32'd0);
        check("q_left1", 32'(exp_q1.size()), 32'd0);
        check("q_left2", 32'(exp_q2.size()), 32'd0);
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_x18 [8] = '{641, 642, 643, 644, 646, 648, 650, 652};
        int exp_x17 [3] = '{1279, 0, 1};
        int exp_y19 [3] = '{51, 50, 50};
        logic [3:0] pat;
        rst = 1'b1; frame_tick = 1'b0; abilita = 1'b0;
        su = 1'b0; giu = 1'b0; sinistra = 1'b0; destra = 1'b0;
        do_reset();

        // First step right from the centre
        do_tick(1, 0, 0, 0, 1);
        check("first_x", 32'(x_pos[0]), 32'd641);
        check("first_agg", 32'(aggiornato[0]), 32'd1);
        check("first_in_moto", 32'(in_moto[0]), 32'd1);
        @(negedge clk);
        check("first_agg_drop", 32'(aggiornato[0]), 32'd0);

        // Right-edge wrap, then left-edge wrap
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_tick(1, 0, 0, 0, 1);
            check($sformatf("wrap_r%0d", i), 32'(x_pos[1]), 32'(exp_x17[i]));
        end
        do_reset();
        do_tick(1, 0, 0, 1, 0);
        check("wrap_l", 32'(x_pos[2]), 32'd1279);

        // Acceleration, release, and reset in the middle of a run
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_tick(1, 0, 0, 0, 1);
            check($sformatf("accel%0d", i), 32'(x_pos[0]), 32'(exp_x18[i]));
        end
        do_tick(1, 0, 0, 0, 0);
        check("release_x", 32'(x_pos[0]), 32'd652);
        check("release_in_moto", 32'(in_moto[0]), 32'd0);
        check("release_vel", 32'(vel[0]), 32'd1);
        for (int i = 0; i < 8; i++) do_tick(1, 0, 0, 0, 1);
        check("rerun_x", 32'(x_pos[0]), 32'd664);
        do_reset();
        do_tick(1, 0, 0, 0, 1);
        check("post_rst_x", 32'(x_pos[0]), 32'd641);

        // Vertical clamps
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_tick(1, 1, 0, 0, 0);
            check($sformatf("clamp_up%0d", i), 32'(y_pos[1]), 32'(exp_y19[i]));
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_tick(1, 0, 1, 0, 0);
            check($sformatf("clamp_dn%0d", i), 32'(y_pos[2]), 32'd973);
        end

        // Opposing horizontal inputs cancel; disabled tick freezes everything
        do_reset();
        do_tick(1, 0, 1, 1, 1);
        check("cancel_x", 32'(x_pos[0]), 32'd640);
        check("cancel_y", 32'(y_pos[0]), 32'd513);
        do_tick(0, 0, 1, 1, 1);
        check("dis_x", 32'(x_pos[0]), 32'd640);
        check("dis_y", 32'(y_pos[0]), 32'd513);
        check("dis_agg", 32'(aggiornato[0]), 32'd0);
        check("dis_in_moto", 32'(in_moto[0]), 32'd0);

        // Random held patterns, long enough to reach the saturated step
        do_reset();
        pat = 4'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            if ($urandom_range(0, 11) == 0) pat = 4'($urandom_range(0, 15));
            do_tick($urandom_range(0, 14) != 0, pat[3], pat[2], pat[1], pat[0]);
        end

        repeat (3) @(negedge clk);
        check("end_q0", 32'(exp_q0.size()), 32'd0);
        check("end_q1", 32'(exp_q1.size()), 32'd0);
        check("end_q2", 32'(exp_q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
